// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants and FSM state type for the 2D DCT scheduler
package dct_pkg;

  localparam int DCT_DATA_WIDTH = 32;
  localparam int N = 8;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_ROW_START = 3'd1,
    ST_ROW_WAIT  = 3'd2,
    ST_COL_START = 3'd3,
    ST_COL_WAIT  = 3'd4,
    ST_DRAIN     = 3'd5
  } dct_state_e;

  function automatic logic is_wait(input dct_state_e s);
    return (s == ST_ROW_WAIT) || (s == ST_COL_WAIT);
  endfunction

endpackage

// File: rtl/dct2d_tbuf.sv
// rtl/dct2d_tbuf.sv - 8x8 sample buffer with row or column write and row or column read
// One write port and one read port; wr_col/rd_col pick the orientation.
module dct2d_tbuf
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic                    wr_col,
  input  logic [2:0]              waddr,
  input  logic [N*DATA_WIDTH-1:0] wdata,
  input  logic                    rd_col,
  input  logic [2:0]              raddr,
  output logic [N*DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [N][N];
  logic [DATA_WIDTH-1:0] mem_d [N][N];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int k = 0; k < N; k++) begin
        if (wr_col) begin
          mem_d[k][waddr] = wdata[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          mem_d[waddr][k] = wdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < N; k++) begin
      rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd_col ? mem_q[k][raddr] : mem_q[raddr][k];
    end
  end

endmodule

// File: rtl/dct2d_sched.sv
// rtl/dct2d_sched.sv - row/column scheduler wrapping an external 1D DCT into an 8x8 2D DCT
// Optional WAIT watchdog with sticky err output: DCT2D_SCHED_TIMEOUT_EN.
module dct2d_sched
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH     = DCT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_WIDTH-1:0] in_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*DATA_WIDTH-1:0] out_row,
  output logic                    dct_start,
  output logic [8*DATA_WIDTH-1:0] dct_x,
  input  logic [8*DATA_WIDTH-1:0] dct_y,
  input  logic                    dct_valid,
  output logic                    busy
`ifdef DCT2D_SCHED_TIMEOUT_EN
  ,
  output logic                    err
`endif
);

  localparam int RW = 8 * DATA_WIDTH;

  dct_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       out_valid_q, out_valid_d;
  logic [RW-1:0] out_row_q, out_row_d;

  logic          capture;
  logic          timeout;
  logic          a_we, a_wr_col, b_we;
  logic [2:0]    a_raddr;
  logic [RW-1:0] a_wdata, a_rdata, b_rdata;

  assign capture = is_wait(state_q) && dct_valid;

  // A holds input rows, then the final coefficients; B holds the row-pass result.
  dct2d_tbuf #(.DATA_WIDTH(DATA_WIDTH)) u_buf_a (
    .clk    (clk),
    .we     (a_we),
    .wr_col (a_wr_col),
    .waddr  (idx_q),
    .wdata  (a_wdata),
    .rd_col (1'b0),
    .raddr  (a_raddr),
    .rdata  (a_rdata)
  );

  dct2d_tbuf #(.DATA_WIDTH(DATA_WIDTH)) u_buf_b (
    .clk    (clk),
    .we     (b_we),
    .wr_col (1'b0),
    .waddr  (idx_q),
    .wdata  (dct_y),
    .rd_col (1'b1),
    .raddr  (idx_q),
    .rdata  (b_rdata)
  );

`ifdef DCT2D_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  assign timeout = is_wait(state_q) && !dct_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = is_wait(state_q) ? tmo_q + TMO_W'(1) : '0;
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;

  // The watchdog length is meaningless without the watchdog.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_ROW_START;
        end
      end
      ST_ROW_START: state_d = ST_ROW_WAIT;
      ST_ROW_WAIT: begin
        if (capture) begin
          idx_d   = idx_q + 3'd1;
          state_d = (idx_q == 3'd7) ? ST_COL_START : ST_ROW_START;
        end
      end
      ST_COL_START: state_d = ST_COL_WAIT;
      ST_COL_WAIT: begin
        if (capture) begin
          idx_d   = idx_q + 3'd1;
          state_d = (idx_q == 3'd7) ? ST_DRAIN : ST_COL_START;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = '0;
      end
    endcase
    if (timeout) begin
      state_d = ST_LOAD;
      idx_d   = '0;
    end
  end

  always_comb begin
    in_ready    = (state_q == ST_LOAD);
    dct_start   = (state_q == ST_ROW_START) || (state_q == ST_COL_START);
    busy        = (state_q != ST_LOAD) || (idx_q != 3'd0);
    dct_x       = '0;
    a_we        = 1'b0;
    a_wr_col    = 1'b0;
    a_wdata     = dct_y;
    a_raddr     = idx_q;
    b_we        = 1'b0;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    unique case (state_q)
      ST_LOAD: begin
        a_we    = in_valid;
        a_wdata = in_row;
      end
      ST_ROW_START: dct_x = a_rdata;
      ST_ROW_WAIT: begin
        dct_x = a_rdata;
        b_we  = capture;
      end
      ST_COL_START: dct_x = b_rdata;
      ST_COL_WAIT: begin
        dct_x    = b_rdata;
        a_we     = capture;
        a_wr_col = 1'b1;
      end
      ST_DRAIN: begin
        // First DRAIN cycle prefetches row 0; each handshake then prefetches the next row.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_row_d   = a_rdata;
        end else if (out_ready) begin
          a_raddr = idx_q + 3'd1;
          if (idx_q == 3'd7) out_valid_d = 1'b0;
          else               out_row_d   = a_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;

endmodule

// File: tb/tb_dct2d_sched.sv
// tb/tb_dct2d_sched.sv - scoreboard bench for dct2d_sched with a latency-3 1D DCT mock
module tb_dct2d_sched;

  localparam int W  = 32;
  localparam int RW = 8 * W;
  typedef logic [RW-1:0] row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic dct_valid = 1'b0;
  row_t in_row = '0;
  row_t dct_y = '0;
  logic in_ready, out_valid, dct_start, busy;
  row_t out_row, dct_x;
`ifdef DCT2D_SCHED_TIMEOUT_EN
  logic err;
`endif

  dct2d_sched #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .dct_start (dct_start),
    .dct_x     (dct_x),
    .dct_y     (dct_y),
    .dct_valid (dct_valid),
    .busy      (busy)
`ifdef DCT2D_SCHED_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int mock_mode = 0;   // 0 identity, 1 reversal, 2 rotate+offset, 3 silent
  int rdy_mode = 0;    // 0 always ready, 1 random, 2 stall 5 cycles at row 3
  bit skip_x = 1'b0;
  bit arm = 1'b0;
  int acc_edge = -1000;
  int rows_in_blk = 0;
  row_t exp_q[$];
  row_t cur_blk[8];

  task automatic check(input string name, input row_t got, input row_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic row_t f1d(input row_t x, input int mode);
    row_t y = '0;
    logic [W-1:0] v;
    for (int k = 0; k < 8; k++) begin
      case (mode)
        0:       v = x[k*W +: W];
        1:       v = x[(7-k)*W +: W];
        2:       v = x[((k+3)%8)*W +: W] + (32'(k) * 32'h0001_0001);
        default: v = '0;
      endcase
      y[k*W +: W] = v;
    end
    return y;
  endfunction

  // 2D result = 1D transform on every row, then on every column, read out row-major.
  task automatic push_expected();
    row_t b[8];
    row_t a[8];
    row_t v, w;
    for (int r = 0; r < 8; r++) b[r] = f1d(cur_blk[r], mock_mode);
    for (int c = 0; c < 8; c++) begin
      v = '0;
      for (int k = 0; k < 8; k++) v[k*W +: W] = b[k][c*W +: W];
      w = f1d(v, mock_mode);
      for (int k = 0; k < 8; k++) a[k][c*W +: W] = w[k*W +: W];
    end
    for (int r = 0; r < 8; r++) exp_q.push_back(a[r]);
  endtask

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // 1D DCT mock: dct_valid 3 cycles after dct_start, then one extra garbage-valid cycle.
  initial begin
    int cnt = 0;
    bit tail = 1'b0;
    row_t xv = '0;
    forever begin
      @(negedge clk);
      if (tail) begin
        dct_valid = 1'b0;
        tail = 1'b0;
      end
      if (dct_valid) begin
        dct_y = ~dct_y;
        tail = 1'b1;
      end
      if (cnt > 0) begin
        if (!skip_x) check("dct_x_hold", dct_x, xv);
        cnt--;
        if (cnt == 0 && mock_mode != 3) begin
          dct_valid = 1'b1;
          dct_y = f1d(xv, mock_mode);
        end
      end
      if (dct_start) begin
        xv = dct_x;
        cnt = 3;
      end
    end
  end

  initial begin
    int stall_done = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (rows_in_blk == 3 && stall_done < 5) begin
            out_ready = 1'b0;
            stall_done++;
          end else begin
            out_ready = 1'b1;
            if (rows_in_blk != 3) stall_done = 0;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    bit prev_valid = 1'b0;
    bit hold_chk = 1'b0;
    row_t hold_row = '0;
    int last_lat = -1000;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_valid && arm && acc_edge != last_lat) begin
        check("first_out_latency", row_t'(edge_cnt - acc_edge), row_t'(65));
        last_lat = acc_edge;
      end
      if (hold_chk) begin
        check("stall_valid_held", row_t'(out_valid), row_t'(1));
        check("stall_row_held", out_row, hold_row);
        hold_chk = 1'b0;
      end
      if (out_valid) check("in_ready_low_in_drain", row_t'(in_ready), row_t'(0));
      if (out_valid && !out_ready) begin
        hold_chk = 1'b1;
        hold_row = out_row;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_row", out_row, '0);
          bad += (out_row === '0) ? 1 : 0;
        end else begin
          check("out_row", out_row, exp_q.pop_front());
        end
        rows_in_blk = (rows_in_blk + 1) % 8;
      end
      prev_valid = out_valid;
    end
  end

  task automatic send_block(input bit push, input bit do_arm, input bit hold);
    int n;
    if (push) push_expected();
    for (int i = 0; i < 8; i++) begin
      in_row = cur_blk[i];
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        check("in_accept_timeout", row_t'(in_ready), row_t'(1));
        in_valid = 1'b0;
        return;
      end
      if (i == 7) begin
        acc_edge = edge_cnt + 1;
        arm = do_arm;
      end
      @(negedge clk);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("block_drained", row_t'(exp_q.size()), row_t'(0));
    check("idle_in_ready", row_t'(in_ready), row_t'(1));
    check("idle_busy", row_t'(busy), row_t'(0));
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        cur_blk[r][c*W +: W] = 32'((8*r + c) << 16);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        cur_blk[r][c*W +: W] = $urandom;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", row_t'(in_ready), row_t'(1));
    check("rst_out_valid", row_t'(out_valid), row_t'(0));
    check("rst_busy", row_t'(busy), row_t'(0));
    check("rst_dct_start", row_t'(dct_start), row_t'(0));
    check("rst_dct_x", dct_x, '0);
    check("rst_out_row", out_row, '0);
`ifdef DCT2D_SCHED_TIMEOUT_EN
    check("rst_err", row_t'(err), row_t'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    mock_mode = 0; rdy_mode = 0; fill_ramp();
    send_block(1, 1, 0);
    wait_idle();

    mock_mode = 1; fill_ramp();
    send_block(1, 1, 0);
    wait_idle();

    mock_mode = 2; rdy_mode = 2; fill_random();
    send_block(1, 1, 0);
    wait_idle();

    rdy_mode = 1;
    for (int b = 0; b < 3; b++) begin
      mock_mode = (b == 1) ? 1 : 2;
      fill_random();
      send_block(1, 1, 0);
      wait_idle();
    end

    // in_valid stays high through compute and drain of the first block.
    mock_mode = 2; fill_random();
    send_block(1, 1, 1);
    fill_random();
    send_block(1, 1, 0);
    wait_idle();

    // Reset during ROW_WAIT of row 4.
    rdy_mode = 0; mock_mode = 0; skip_x = 1'b1; fill_random();
    send_block(0, 0, 0);
    s = 0; n = 0;
    while (n < 2000) begin
      if (dct_start) s++;
      if (s >= 5) break;
      @(negedge clk);
      n++;
    end
    check("reset_point_reached", row_t'(s), row_t'(5));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", row_t'(in_ready), row_t'(1));
    check("midrst_out_valid", row_t'(out_valid), row_t'(0));
    check("midrst_busy", row_t'(busy), row_t'(0));
    check("midrst_dct_start", row_t'(dct_start), row_t'(0));
    repeat (5) @(negedge clk);
    skip_x = 1'b0;
    fill_ramp();
    send_block(1, 1, 0);
    wait_idle();

`ifdef DCT2D_SCHED_TIMEOUT_EN
    mock_mode = 3; fill_random();
    send_block(0, 0, 0);
    n = 0;
    while (edge_cnt < acc_edge + 64 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("tmo_err_before", row_t'(err), row_t'(0));
    @(negedge clk);
    check("tmo_err_set", row_t'(err), row_t'(1));
    check("tmo_in_ready", row_t'(in_ready), row_t'(1));
    check("tmo_busy", row_t'(busy), row_t'(0));
    repeat (10) @(negedge clk);
    check("tmo_err_sticky", row_t'(err), row_t'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("tmo_err_cleared", row_t'(err), row_t'(0));
    mock_mode = 0;
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
